// File: rtl/fifo_flow_pkg.sv
// Shared types and sizing helpers for the fifo_flow FIFO and its benches.
package fifo_flow_pkg;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

endpackage

// File: rtl/fifo_flow_mem.sv
// DEPTH x D_WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_flow_mem #(
   parameter int D_WIDTH = 6,
   parameter int DEPTH   = 4
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [D_WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [D_WIDTH-1:0]         rdata_o
);

   logic [D_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flow.sv
// First-word-fall-through FIFO with count, flags and sticky error bits.
// Optional high-water mark on `peak` when FIFO_FLOW_STATS_EN is defined.
module fifo_flow
   import fifo_flow_pkg::*;
#(
   parameter int D_WIDTH   = 6,
   parameter int DEPTH     = 4,
   parameter int AFULL_LVL = DEPTH - 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [D_WIDTH-1:0]        up_data,
   input  logic                      push,
   output logic [D_WIDTH-1:0]        down_data,
   input  logic                      pop,
   output logic                      full,
   output logic                      empty,
   output logic                      afull,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      overflow,
   output logic                      underflow,
   output logic [cnt_w(DEPTH)-1:0]   peak
);

   localparam int CW = cnt_w(DEPTH);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
   localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   fifo_err_t          err_q, err_d;
   logic               push_acc, pop_acc;
   logic [D_WIDTH-1:0] rd_data;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   assign afull = (count_q >= AFULL_C);
   assign count = count_q;
   assign overflow  = err_q.overflow;
   assign underflow = err_q.underflow;
   assign down_data = empty ? '0 : rd_data;

   always_comb begin
      // when full, a simultaneous pop frees the slot the push needs
      push_acc = push & (~full | pop);
      pop_acc  = pop & ~empty;

      wr_ptr_d = wr_ptr_q;
      if (push_acc) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + AW'(1);
      rd_ptr_d = rd_ptr_q;
      if (pop_acc) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + AW'(1);

      unique case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      err_d           = err_q;
      err_d.overflow  = err_q.overflow  | (push & ~push_acc);
      err_d.underflow = err_q.underflow | (pop & empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

`ifdef FIFO_FLOW_STATS_EN
   logic [CW-1:0] peak_q;

   // count never exceeds DEPTH, so the mark saturates there by construction
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  peak_q <= '0;
      else if (count_d > peak_q) peak_q <= count_d;
   end

   assign peak = peak_q;
`else
   assign peak = '0;
`endif

   fifo_flow_mem #(
      .D_WIDTH (D_WIDTH),
      .DEPTH   (DEPTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (push_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (up_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_fifo_flow.sv
// Self-checking bench for fifo_flow: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_fifo_flow;
   import fifo_flow_pkg::*;

   localparam int DW  = 6;
   localparam int DEP = 4;
   localparam int AFL = 3;
   localparam int CW  = cnt_w(DEP);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] up_data = '0;
   logic          push = 1'b0;
   logic          pop  = 1'b0;
   logic [DW-1:0] down_data;
   logic          full, empty, afull, overflow, underflow;
   logic [CW-1:0] count, peak;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [DW-1:0] mq[$];
   bit            m_ovf, m_unf;
   int            m_pk;

   fifo_flow #(
      .D_WIDTH   (DW),
      .DEPTH     (DEP),
      .AFULL_LVL (AFL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .up_data   (up_data),
      .push      (push),
      .down_data (down_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .afull     (afull),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .peak      (peak)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      m_pk  = 0;
   endtask

   task automatic model_step(input bit p, input bit q, input logic [DW-1:0] d);
      bit is_full, is_empty, pa, qa;
      is_full  = (mq.size() == DEP);
      is_empty = (mq.size() == 0);
      pa = p && (!is_full || q);
      qa = q && !is_empty;
      if (p && !pa) m_ovf = 1;
      if (q && is_empty) m_unf = 1;
      if (qa) void'(mq.pop_front());
      if (pa) mq.push_back(d);
      if (mq.size() > m_pk) m_pk = mq.size();
   endtask

   task automatic check_all(input string tag);
      int sz;
      int exp_pk;
      sz = mq.size();
`ifdef FIFO_FLOW_STATS_EN
      exp_pk = m_pk;
`else
      exp_pk = 0;
`endif
      check({tag, "_count"}, 32'(count), 32'(sz));
      check({tag, "_empty"}, 32'(empty), 32'(sz == 0));
      check({tag, "_full"},  32'(full),  32'(sz == DEP));
      check({tag, "_afull"}, 32'(afull), 32'(sz >= AFL));
      check({tag, "_data"},  32'(down_data), (sz == 0) ? 32'h0 : 32'(mq[0]));
      check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
      check({tag, "_unf"},   32'(underflow), 32'(m_unf));
      check({tag, "_peak"},  32'(peak), 32'(exp_pk));
   endtask

   // Inputs change at negedge; outputs are checked before the edge (no
   // combinational path from push/pop) and 1ns after it.
   task automatic step(input string tag, input bit p, input bit q, input logic [DW-1:0] d);
      @(negedge clk);
      push = p; pop = q; up_data = d;
      #1;
      check_all({tag, "_pre"});
      @(posedge clk);
      model_step(p, q, d);
      #1;
      check_all({tag, "_post"});
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      push = 0; pop = 0;
      #2;
      rst = 1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      // 1: fill
      do_reset("t1_rst");
      step("t1_p0", 1, 0, 6'h11);
      check("t1_head", 32'(down_data), 32'h11);
      check("t1_cnt1", 32'(count), 32'd1);
      step("t1_p1", 1, 0, 6'h22);
      step("t1_p2", 1, 0, 6'h33);
      check("t1_afull", 32'(afull), 32'd1);
      step("t1_p3", 1, 0, 6'h04);
      check("t1_full", 32'(full), 32'd1);
      check("t1_cnt4", 32'(count), 32'd4);

      // 2: overflow then drain
      step("t2_ovf", 1, 0, 6'h3F);
      check("t2_ovf_flag", 32'(overflow), 32'd1);
      check("t2_cnt", 32'(count), 32'd4);
      check("t2_head0", 32'(down_data), 32'h11);
      step("t2_pop0", 0, 1, '0);
      check("t2_head1", 32'(down_data), 32'h22);
      step("t2_pop1", 0, 1, '0);
      check("t2_head2", 32'(down_data), 32'h33);
      step("t2_pop2", 0, 1, '0);
      check("t2_head3", 32'(down_data), 32'h04);
      step("t2_pop3", 0, 1, '0);
      check("t2_empty", 32'(empty), 32'd1);
      check("t2_zero", 32'(down_data), 32'h0);

      // 3: push+pop on empty
      step("t3_pp", 1, 1, 6'h2A);
      check("t3_unf", 32'(underflow), 32'd1);
      check("t3_cnt", 32'(count), 32'd1);
      check("t3_data", 32'(down_data), 32'h2A);

      // 4: push+pop when full
      do_reset("t4_rst");
      for (int i = 0; i < DEP; i++) step("t4_fill", 1, 0, DW'(i + 1));
      step("t4_pp", 1, 1, 6'h15);
      check("t4_cnt", 32'(count), 32'd4);
      check("t4_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < DEP - 1; i++) step("t4_drain", 0, 1, '0);
      check("t4_last", 32'(down_data), 32'h15);
      step("t4_drain_last", 0, 1, '0);
      check("t4_empty", 32'(empty), 32'd1);

      // 5: reset mid-stream
      do_reset("t5_rst0");
      for (int i = 0; i < 3; i++) step("t5_fill", 1, 0, DW'(8 + i));
      do_reset("t5_rst");
      check("t5_cnt", 32'(count), 32'd0);
      check("t5_data", 32'(down_data), 32'h0);
      step("t5_push", 1, 0, 6'h07);
      check("t5_head", 32'(down_data), 32'h07);

      // 6: high-water mark
      do_reset("t6_rst");
      for (int i = 0; i < 3; i++) step("t6_push", 1, 0, DW'(i));
      for (int i = 0; i < 2; i++) step("t6_pop", 0, 1, '0);
      step("t6_push2", 1, 0, 6'h30);
`ifdef FIFO_FLOW_STATS_EN
      check("t6_peak", 32'(peak), 32'd3);
`else
      check("t6_peak", 32'(peak), 32'd0);
`endif

      // randomized traffic with drifting push/pop bias so full and empty both occur
      do_reset("rnd_rst");
      for (int cyc = 0; cyc < 10000; cyc++) begin
         int bias;
         bit p, q;
         bias = ((cyc / 200) % 2 == 0) ? 70 : 30;
         p = ($urandom_range(99) < bias);
         q = ($urandom_range(99) < (100 - bias));
         if (cyc % 2500 == 2499) do_reset("rnd_rst_mid");
         step("rnd", p, q, DW'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
